// File: rtl/block_a_seq_ctrl.sv
// Source-side sequencer for blockA: runs N aStuff req/ack + cStuff rdy/vld pairs,
// then a startDone notify/ack, reporting progress, timeout and abort status.
module block_a_seq_ctrl #(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 8,
    parameter int TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic [DATA_W-1:0] cfg_base,
    input  logic              cfg_abort,
    output logic              a_req,
    output logic [DATA_W-1:0] a_data,
    input  logic              a_ack,
    output logic              c_vld,
    output logic [DATA_W-1:0] c_data,
    input  logic              c_rdy,
    output logic              done_notify,
    input  logic              done_ack,
    output logic              st_busy,
    output logic [CNT_W-1:0]  st_xfer_cnt,
    output logic              st_timeout,
    output logic              st_aborted
);

    // The wait counter only has to reach TMO_CYC-1: the timeout fires at the end of that cycle.
    localparam int                WAIT_W    = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam bit                TMO_EN    = (TMO_CYC != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TMO_CYC > 0) ? WAIT_W'(TMO_CYC - 1) : '0;

    typedef enum logic [2:0] {IDLE, A_REQ, C_XFER, NOTIFY, ERR} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_remaining;
    logic [CNT_W-1:0]    r_xfer_cnt;
    logic [DATA_W-1:0]   r_payload;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_timeout;
    logic                r_aborted;
    logic                w_start;
    logic                w_done;
    logic                w_set_tmo;
    logic                w_set_abort;
    logic                w_abort;
    logic                w_tmo_hit;
    logic                w_a_req;
    logic                w_c_vld;

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_set_tmo   = 1'b0;
        w_set_abort = 1'b0;
        w_abort     = cfg_abort && (r_state inside {A_REQ, C_XFER, NOTIFY});
        w_tmo_hit   = TMO_EN && (r_wait == WAIT_LAST);
        // Priority in every wait state: abort, then handshake, then timeout.
        case (r_state)
            IDLE: begin
                if (cfg_start) begin
                    w_start = 1'b1;
                    w_next  = (cfg_count != '0) ? A_REQ : NOTIFY;
                end
            end
            A_REQ: begin
                if (w_abort) begin
                    w_set_abort = 1'b1;
                    w_next      = ERR;
                end else if (a_ack) begin
                    w_next = C_XFER;
                end else if (w_tmo_hit) begin
                    w_set_tmo = 1'b1;
                    w_next    = ERR;
                end
            end
            C_XFER: begin
                if (w_abort) begin
                    w_set_abort = 1'b1;
                    w_next      = ERR;
                end else if (c_rdy) begin
                    w_done = 1'b1;
                    w_next = (r_remaining > CNT_W'(1)) ? A_REQ : NOTIFY;
                end else if (w_tmo_hit) begin
                    w_set_tmo = 1'b1;
                    w_next    = ERR;
                end
            end
            NOTIFY: begin
                if (w_abort) begin
                    w_set_abort = 1'b1;
                    w_next      = ERR;
                end else if (done_ack) begin
                    w_next = IDLE;
                end else if (w_tmo_hit) begin
                    w_set_tmo = 1'b1;
                    w_next    = ERR;
                end
            end
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_xfer_cnt  <= '0;
            r_payload   <= '0;
            r_wait      <= '0;
            r_timeout   <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_next != r_state) ? '0 : r_wait + 1'b1;
            if (w_start) begin
                r_remaining <= cfg_count;
                r_payload   <= cfg_base;
                r_xfer_cnt  <= '0;
                r_timeout   <= 1'b0;
                r_aborted   <= 1'b0;
            end
            if (w_done) begin
                r_remaining <= r_remaining - 1'b1;
                r_payload   <= r_payload + 1'b1;
                if (r_xfer_cnt != '1) begin
                    r_xfer_cnt <= r_xfer_cnt + 1'b1;
                end
            end
            if (w_set_tmo) begin
                r_timeout <= 1'b1;
            end
            if (w_set_abort) begin
                r_aborted <= 1'b1;
            end
        end
    end

    // Strobes decode straight from the state register, so at most one is ever high.
    assign w_a_req     = (r_state == A_REQ);
    assign w_c_vld     = (r_state == C_XFER);
    assign a_req       = w_a_req;
    assign c_vld       = w_c_vld;
    assign a_data      = w_a_req ? r_payload : '0;
    assign c_data      = w_c_vld ? ~r_payload : '0;
    assign done_notify = (r_state == NOTIFY);
    assign st_busy     = (r_state != IDLE);
    assign st_xfer_cnt = r_xfer_cnt;
    assign st_timeout  = r_timeout;
    assign st_aborted  = r_aborted;

endmodule

// File: tb/tb_block_a_seq_ctrl.sv
// Scoreboard bench for block_a_seq_ctrl: directed runs push expected handshakes,
// a negedge monitor pops and compares them; a second instance covers timeout.
module tb_block_a_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        cfg_start = 1'b0, cfg_abort = 1'b0;
    logic [7:0]  cfg_count = '0;
    logic [31:0] cfg_base = '0;
    logic        a_req, c_vld, done_notify, st_busy, st_timeout, st_aborted;
    logic [31:0] a_data, c_data;
    logic [7:0]  st_xfer_cnt;
    logic        a_ack = 1'b0, c_rdy = 1'b0, done_ack = 1'b0;

    logic        t_cfg_start = 1'b0, t_cfg_abort = 1'b0;
    logic [7:0]  t_cfg_count = '0;
    logic [31:0] t_cfg_base = '0;
    logic        t_a_req, t_c_vld, t_done_notify, t_st_busy, t_st_timeout, t_st_aborted;
    logic [31:0] t_a_data, t_c_data;
    logic [7:0]  t_st_xfer_cnt;
    logic        t_a_ack = 1'b0, t_c_rdy = 1'b0, t_done_ack = 1'b0;

    block_a_seq_ctrl #(.DATA_W(32), .CNT_W(8), .TMO_CYC(255)) u_dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_count(cfg_count),
        .cfg_base(cfg_base), .cfg_abort(cfg_abort), .a_req(a_req), .a_data(a_data),
        .a_ack(a_ack), .c_vld(c_vld), .c_data(c_data), .c_rdy(c_rdy),
        .done_notify(done_notify), .done_ack(done_ack), .st_busy(st_busy),
        .st_xfer_cnt(st_xfer_cnt), .st_timeout(st_timeout), .st_aborted(st_aborted)
    );

    block_a_seq_ctrl #(.DATA_W(32), .CNT_W(8), .TMO_CYC(4)) u_tmo (
        .clk(clk), .rst(rst), .cfg_start(t_cfg_start), .cfg_count(t_cfg_count),
        .cfg_base(t_cfg_base), .cfg_abort(t_cfg_abort), .a_req(t_a_req), .a_data(t_a_data),
        .a_ack(t_a_ack), .c_vld(t_c_vld), .c_data(t_c_data), .c_rdy(t_c_rdy),
        .done_notify(t_done_notify), .done_ack(t_done_ack), .st_busy(t_st_busy),
        .st_xfer_cnt(t_st_xfer_cnt), .st_timeout(t_st_timeout), .st_aborted(t_st_aborted)
    );

    localparam int K_A = 0, K_C = 1, K_N = 2;
    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;
    exp_t q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic sb_pop(input string name, input int kind, input logic [31:0] act);
        exp_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected handshake value 0x%0h, nothing expected @%0t", name, act, $time);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.val !== act) begin
                n_fail++;
                $display("FAIL %s: got kind %0d value 0x%0h expected kind %0d value 0x%0h @%0t",
                         name, kind, act, e.kind, e.val, $time);
            end
        end
    endtask

    // Monitor: handshakes are sampled mid-cycle, where inputs and state are both settled.
    logic        prev_a_req = 1'b0, prev_c_vld = 1'b0;
    logic [31:0] prev_a_data = '0, prev_c_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("onehot", 32'($countones({a_req, c_vld, done_notify}) <= 1), 32'd1);
            chk("onehot_tmo", 32'($countones({t_a_req, t_c_vld, t_done_notify}) <= 1), 32'd1);
            if (prev_a_req && a_req) chk("a_data_stable", a_data, prev_a_data);
            if (prev_c_vld && c_vld) chk("c_data_stable", c_data, prev_c_data);
            if (a_req && a_ack && !cfg_abort) sb_pop("sb_a", K_A, a_data);
            if (c_vld && c_rdy && !cfg_abort) sb_pop("sb_c", K_C, c_data);
            if (done_notify && done_ack && !cfg_abort) sb_pop("sb_n", K_N, 32'(st_xfer_cnt));
        end
        prev_a_req  <= a_req && !rst;
        prev_c_vld  <= c_vld && !rst;
        prev_a_data <= a_data;
        prev_c_data <= c_data;
    end

    task automatic start_run(input logic [7:0] cnt, input logic [31:0] base);
        @(posedge clk); #1;
        cfg_count = cnt;
        cfg_base  = base;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_notify(output int strobes);
        strobes = 0;
        for (int i = 0; i < 200 && !done_notify; i++) begin
            if (a_req || c_vld) strobes++;
            @(posedge clk); #1;
        end
        if (!done_notify) begin
            n_cmp++;
            n_fail++;
            $display("FAIL notify_wait: done_notify never rose within 200 cycles @%0t", $time);
        end
    endtask

    task automatic ack_notify();
        done_ack = 1'b1;
        @(posedge clk); #1;
        done_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int strobes;
        int aw;
        int n;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_req", a_req, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_c_vld", c_vld, 0);
        chk("rst_c_data", c_data, 0);
        chk("rst_notify", done_notify, 0);
        chk("rst_busy", st_busy, 0);
        chk("rst_xfer", st_xfer_cnt, 0);
        chk("rst_tmo", st_timeout, 0);
        chk("rst_abort", st_aborted, 0);
        rst = 1'b0;

        // count=3, base=0x10, immediate ack/rdy
        a_ack = 1'b1;
        c_rdy = 1'b1;
        push(K_A, 32'h10); push(K_C, 32'hFFFF_FFEF);
        push(K_A, 32'h11); push(K_C, 32'hFFFF_FFEE);
        push(K_A, 32'h12); push(K_C, 32'hFFFF_FFED);
        push(K_N, 32'd3);
        start_run(8'd3, 32'h10);
        chk("t1_busy", st_busy, 1);
        chk("t1_xfer_clr", st_xfer_cnt, 0);
        wait_notify(strobes);
        chk("t1_strobes", strobes, 6);
        chk("t1_xfer", st_xfer_cnt, 3);
        ack_notify();
        chk("t1_busy_end", st_busy, 0);
        chk("t1_notify_end", done_notify, 0);

        // count=0: notify only
        push(K_N, 32'd0);
        start_run(8'd0, 32'h55);
        chk("t2_notify", done_notify, 1);
        chk("t2_a_req", a_req, 0);
        chk("t2_c_vld", c_vld, 0);
        wait_notify(strobes);
        chk("t2_strobes", strobes, 0);
        ack_notify();
        chk("t2_busy_end", st_busy, 0);

        // count=2, a_ack after 5 waiting cycles, c_rdy toggling, ignored restart
        a_ack = 1'b0;
        c_rdy = 1'b0;
        push(K_A, 32'h20); push(K_C, 32'hFFFF_FFDF);
        push(K_A, 32'h21); push(K_C, 32'hFFFF_FFDE);
        push(K_N, 32'd2);
        start_run(8'd2, 32'h20);
        aw = 0;
        for (int cyc = 0; cyc < 200 && !done_notify; cyc++) begin
            if (a_req) begin
                aw++;
                a_ack = (aw > 5);
            end else begin
                aw    = 0;
                a_ack = 1'b0;
            end
            c_rdy     = ~c_rdy;
            cfg_start = (cyc == 3);
            cfg_count = 8'd9;
            @(posedge clk); #1;
        end
        cfg_start = 1'b0;
        chk("t3_notify", done_notify, 1);
        chk("t3_xfer", st_xfer_cnt, 2);
        ack_notify();
        chk("t3_busy_end", st_busy, 0);

        // timeout on the TMO_CYC=4 instance, then a clean rerun
        t_a_ack = 1'b1;
        t_c_rdy = 1'b0;
        @(posedge clk); #1;
        t_cfg_count = 8'd1;
        t_cfg_base  = 32'h7;
        t_cfg_start = 1'b1;
        @(posedge clk); #1;
        t_cfg_start = 1'b0;
        chk("t4_a_req", t_a_req, 1);
        chk("t4_a_data", t_a_data, 32'h7);
        @(posedge clk); #1;
        chk("t4_c_data", t_c_data, 32'hFFFF_FFF8);
        n = 0;
        while (t_c_vld && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk("t4_vld_cycles", n, 4);
        chk("t4_c_vld_off", t_c_vld, 0);
        chk("t4_timeout", t_st_timeout, 1);
        chk("t4_aborted", t_st_aborted, 0);
        @(posedge clk); #1;
        chk("t4_busy", t_st_busy, 0);
        chk("t4_xfer", t_st_xfer_cnt, 0);
        t_c_rdy = 1'b1;
        @(posedge clk); #1;
        t_cfg_start = 1'b1;
        @(posedge clk); #1;
        t_cfg_start = 1'b0;
        chk("t4b_tmo_clr", t_st_timeout, 0);
        chk("t4b_a_req", t_a_req, 1);
        n = 0;
        while (!t_done_notify && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk("t4b_notify", t_done_notify, 1);
        chk("t4b_xfer", t_st_xfer_cnt, 1);
        t_done_ack = 1'b1;
        @(posedge clk); #1;
        t_done_ack = 1'b0;
        chk("t4b_busy_end", t_st_busy, 0);
        chk("t4b_tmo_end", t_st_timeout, 0);

        // abort during the second A_REQ of count=5
        a_ack = 1'b0;
        c_rdy = 1'b1;
        push(K_A, 32'h40); push(K_C, 32'hFFFF_FFBF);
        start_run(8'd5, 32'h40);
        a_ack = 1'b1;
        @(posedge clk); #1;
        a_ack = 1'b0;
        @(posedge clk); #1;
        chk("t5_a_req2", a_req, 1);
        chk("t5_a_data2", a_data, 32'h41);
        chk("t5_xfer_mid", st_xfer_cnt, 1);
        cfg_abort = 1'b1;
        @(posedge clk); #1;
        cfg_abort = 1'b0;
        chk("t5_a_req_off", a_req, 0);
        chk("t5_aborted", st_aborted, 1);
        chk("t5_timeout", st_timeout, 0);
        chk("t5_xfer", st_xfer_cnt, 1);
        @(posedge clk); #1;
        chk("t5_busy", st_busy, 0);

        // reset in the middle of C_XFER
        a_ack = 1'b1;
        c_rdy = 1'b0;
        push(K_A, 32'h80);
        start_run(8'd3, 32'h80);
        @(posedge clk); #1;
        chk("t6_c_vld", c_vld, 1);
        chk("t6_c_data", c_data, 32'hFFFF_FF7F);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_a_req", a_req, 0);
        chk("t6_a_data", a_data, 0);
        chk("t6_c_vld_off", c_vld, 0);
        chk("t6_c_data_off", c_data, 0);
        chk("t6_notify", done_notify, 0);
        chk("t6_busy", st_busy, 0);
        chk("t6_xfer", st_xfer_cnt, 0);
        chk("t6_tmo", st_timeout, 0);
        chk("t6_abort", st_aborted, 0);
        rst = 1'b0;

        // payload wrap
        a_ack = 1'b1;
        c_rdy = 1'b1;
        push(K_A, 32'hFFFF_FFFF); push(K_C, 32'h0000_0000);
        push(K_A, 32'h0000_0000); push(K_C, 32'hFFFF_FFFF);
        push(K_N, 32'd2);
        start_run(8'd2, 32'hFFFF_FFFF);
        wait_notify(strobes);
        chk("t7_strobes", strobes, 4);
        ack_notify();
        chk("t7_busy_end", st_busy, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
